// File: rtl/pc_unit_pkg.sv
// Shared processor constants: fetch FSM state encoding and default address width.
package pc_unit_pkg;

    localparam int unsigned PcWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_unit_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with IDLE/RUN/HALT fetch control, branch redirect, wrong-path flush
// and a saturating count of taken redirects.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     WIDTH    = PcWidth,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             take,
    input  logic [WIDTH-1:0] target,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc,
    output logic             flush,
    output logic             running,
    output logic             halted,
    output logic [15:0]      branch_cnt
);

    pc_state_e        state_d, state_q;
    logic [WIDTH-1:0] pc_d, pc_q;
    logic             flush_d, flush_q;
    logic             redirect;

    // Priority in RUN: halt_req > take > stall > increment.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        redirect = 1'b0;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (take) begin
                    pc_d     = target;
                    flush_d  = 1'b1;
                    redirect = 1'b1;
                end else if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_branch_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .inc_i   (redirect),
        .count_o (branch_cnt)
    );

    assign pc      = pc_q;
    assign flush   = flush_q;
    assign running = (state_q == StRun);
    assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against a model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        take = 1'b0;
    logic [15:0] target = '0;
    logic        halt_req = 1'b0;
    logic [15:0] pc;
    logic        flush;
    logic        running;
    logic        halted;
    logic [15:0] branch_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: mode as two flags, plain integer arithmetic.
    bit          m_run, m_halt, m_flush;
    int unsigned m_pc, m_cnt;

    pc_unit #(
        .WIDTH    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .take       (take),
        .target     (target),
        .halt_req   (halt_req),
        .pc         (pc),
        .flush      (flush),
        .running    (running),
        .halted     (halted),
        .branch_cnt (branch_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_flush = 0; m_pc = 0; m_cnt = 0;
    endtask

    // Apply one cycle of inputs, clock it, and advance the model.
    task automatic cyc(input logic s, input logic st, input logic tk,
                       input logic [15:0] tg, input logic h);
        start = s; stall = st; take = tk; target = tg; halt_req = h;
        @(posedge clk);
        #1;
        m_flush = 0;
        if (m_run) begin
            if (h) begin
                m_run = 0; m_halt = 1;
            end else if (tk) begin
                m_pc = tg; m_flush = 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (!st) begin
                m_pc = (m_pc + 1) % 65536;
            end
        end else if (s) begin
            m_run = 1; m_halt = 0;
        end
        start = 0; stall = 0; take = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic run_to(input int unsigned n);
        cyc(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < int'(n); i++) cyc(0, 0, 0, 16'h0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc got %h want 0000", pc); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", flush); end
        n_vec++; if (running !== 1'b0 || halted !== 1'b0) begin
            n_err++; $display("FAIL reset_state got run=%b halt=%b want 0/0", running, halted);
        end
        n_vec++; if (branch_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", branch_cnt); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'($urandom), 1, 16'h1234, 1'($urandom));
            n_vec++;
            if (pc !== 16'h0 || running !== 1'b0 || halted !== 1'b0 || flush !== 1'b0) begin
                n_err++;
                $display("FAIL idle_hold got pc=%h run=%b halt=%b flush=%b want 0000/0/0/0",
                         pc, running, halted, flush);
            end
        end
    endtask

    task automatic test_count_up();
        do_reset();
        cyc(1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (pc !== 16'(i) || running !== 1'b1) begin
                n_err++; $display("FAIL count_up got pc=%h run=%b want %h/1", pc, running, 16'(i));
            end
            if (i < 3) cyc(0, 0, 0, 16'h0, 0);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_to(5);
        n_vec++; if (pc !== 16'h0005) begin n_err++; $display("FAIL branch_pre got %h want 0005", pc); end
        cyc(0, 0, 1, 16'h0040, 0);
        n_vec++; if (pc !== 16'h0040 || flush !== 1'b1) begin
            n_err++; $display("FAIL branch_load got pc=%h flush=%b want 0040/1", pc, flush);
        end
        n_vec++; if (branch_cnt !== 16'd1) begin n_err++; $display("FAIL branch_cnt got %0d want 1", branch_cnt); end
        cyc(0, 0, 0, 16'h0, 0);
        n_vec++; if (pc !== 16'h0041 || flush !== 1'b0) begin
            n_err++; $display("FAIL branch_after got pc=%h flush=%b want 0041/0", pc, flush);
        end
    endtask

    task automatic test_stall_branch();
        do_reset();
        run_to(7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 16'h0, 0);
            n_vec++; if (pc !== 16'h0007 || flush !== 1'b0) begin
                n_err++; $display("FAIL stall_hold got pc=%h flush=%b want 0007/0", pc, flush);
            end
        end
        cyc(0, 1, 1, 16'h0100, 0);
        n_vec++; if (pc !== 16'h0100 || flush !== 1'b1) begin
            n_err++; $display("FAIL stall_take got pc=%h flush=%b want 0100/1", pc, flush);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        run_to(0);
        cyc(0, 0, 1, 16'hFFFF, 0);
        cyc(0, 0, 0, 16'h0, 0);
        n_vec++; if (pc !== 16'h0000 || flush !== 1'b0) begin
            n_err++; $display("FAIL wrap got pc=%h flush=%b want 0000/0", pc, flush);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_to(9);
        cyc(0, 0, 1, 16'h0055, 1);
        n_vec++; if (pc !== 16'h0009 || halted !== 1'b1 || running !== 1'b0) begin
            n_err++; $display("FAIL halt_enter got pc=%h halt=%b run=%b want 0009/1/0", pc, halted, running);
        end
        n_vec++; if (branch_cnt !== 16'd0 || flush !== 1'b0) begin
            n_err++; $display("FAIL halt_cnt got cnt=%0d flush=%b want 0/0", branch_cnt, flush);
        end
        cyc(0, 0, 1, 16'h0077, 0);
        n_vec++; if (pc !== 16'h0009 || halted !== 1'b1 || flush !== 1'b0) begin
            n_err++; $display("FAIL halt_hold got pc=%h halt=%b flush=%b want 0009/1/0", pc, halted, flush);
        end
        cyc(1, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 16'h0, 0);
        n_vec++; if (pc !== 16'h000A || running !== 1'b1) begin
            n_err++; $display("FAIL halt_resume got pc=%h run=%b want 000a/1", pc, running);
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        run_to(2);
        cyc(0, 0, 1, 16'h0020, 0);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL rf_pre got flush=%b want 1", flush); end
        #2 reset = 1;
        #1;
        n_vec++; if (flush !== 1'b0 || pc !== 16'h0000) begin
            n_err++; $display("FAIL rf_async got flush=%b pc=%h want 0/0000", flush, pc);
        end
        n_vec++; if (running !== 1'b0 || halted !== 1'b0 || branch_cnt !== 16'h0) begin
            n_err++; $display("FAIL rf_state got run=%b halt=%b cnt=%0d want 0/0/0", running, halted, branch_cnt);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 16'h0, 0);
            n_vec++; if (flush !== 1'b0 || pc !== 16'h0000 || running !== 1'b0) begin
                n_err++; $display("FAIL rf_after got flush=%b pc=%h run=%b want 0/0000/0", flush, pc, running);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] tg;
        do_reset();
        run_to(1);
        for (int i = 1; i <= 3; i++) begin
            tg = 16'(i * 16);
            cyc(0, 0, 1, tg, 0);
            n_vec++; if (pc !== tg || flush !== 1'b1 || branch_cnt !== 16'(i)) begin
                n_err++; $display("FAIL b2b got pc=%h flush=%b cnt=%0d want %h/1/%0d",
                                  pc, flush, branch_cnt, tg, i);
            end
        end
        cyc(0, 0, 0, 16'h0, 0);
        n_vec++; if (pc !== 16'h0031 || flush !== 1'b0 || branch_cnt !== 16'd3) begin
            n_err++; $display("FAIL b2b_end got pc=%h flush=%b cnt=%0d want 0031/0/3", pc, flush, branch_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                16'($urandom), ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 299) == 0) do_reset();
            n_vec++;
            if (pc !== 16'(m_pc) || flush !== m_flush || running !== m_run || halted !== m_halt
                || branch_cnt !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL random[%0d] got pc=%h fl=%b run=%b halt=%b cnt=%0d want %h/%b/%b/%b/%0d",
                         i, pc, flush, running, halted, branch_cnt,
                         16'(m_pc), m_flush, m_run, m_halt, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_branch();
        test_stall_branch();
        test_wrap();
        test_halt();
        test_reset_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning PC and branch-target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, meaning begin or resume fetching.
REQ-006 SHALL have port stall, input, 1, meaning hold PC this cycle (upstream not ready).
REQ-007 SHALL have port take, input, 1, meaning branch/jump taken, driven by the branch decision unit's op output.
REQ-008 SHALL have port target, input, WIDTH, meaning branch destination address, valid when take=1.
REQ-009 SHALL have port halt_req, input, 1, meaning stop fetching (HLT instruction decoded).
REQ-010 SHALL have port pc, output, WIDTH, meaning current fetch address (registered).
REQ-011 SHALL have port flush, output, 1, meaning kill the instruction fetched on the wrong path (registered).
REQ-012 SHALL have port running, output, 1, meaning state is RUN.
REQ-013 SHALL have port halted, output, 1, meaning state is HALT.
REQ-014 SHALL have port branch_cnt, output, 16, meaning count of taken redirects since reset.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and HALT.
REQ-016 SHALL transition IDLE->RUN on start=1; pc holds in IDLE.
REQ-017 SHALL, in RUN, apply priority halt_req > take > stall > increment.
REQ-018 SHALL, in RUN with halt_req=1, hold pc, move to HALT, ignore take, and leave branch_cnt unchanged.
REQ-019 SHALL, in RUN with take=1, load pc<=target even when stall=1; flush=1 in the next cycle only.
REQ-020 SHALL, in RUN with take=1, increment branch_cnt by 1, saturating at 16'hFFFF.
REQ-021 SHALL, in RUN with stall=1 and take=0, hold pc with flush=0.
REQ-022 SHALL, in RUN otherwise, set pc<=pc+1 modulo 2^WIDTH (all-ones wraps to 0, no flag).
REQ-023 SHALL, in HALT, hold pc and move to RUN on start=1; incrementing resumes from the held pc.
REQ-024 SHALL ignore take, stall and halt_req in IDLE and HALT; flush stays 0 there.
REQ-025 SHALL allow back-to-back take cycles; each loads its target, keeps flush high through the cycle after the last take, and counts once.
REQ-026 SHALL derive running and halted combinationally from state only; they are mutually exclusive.

Reset
REQ-027 SHALL, on reset=1 asynchronously, set pc=RESET_PC, state=IDLE, flush=0, branch_cnt=0, running=0 and halted=0.
REQ-028 SHALL, on reset asserted mid-redirect, clear any pending flush immediately; no flush follows deassertion.
REQ-029 SHALL remain in IDLE after reset deassertion until start=1.

Structure
REQ-030 SHALL place the state encodings (IDLE=2'b00, RUN=2'b01, HALT=2'b10) and the WIDTH default in a shared processor constants package/include used by the pipeline.
REQ-031 SHALL be a single module; the saturating counter may be a sub-module named sat_counter.
REQ-032 SHALL register pc, flush, state and branch_cnt, with no combinational path from take to pc.

Verification
REQ-033 SHALL verify: reset, then start=1 for 1 cycle, no stall -> pc steps 0,1,2,3; running=1.
REQ-034 SHALL verify: pc=5, take=1, target=16'h0040 -> next pc=16'h0040; flush=1 for exactly one cycle; branch_cnt=1.
REQ-035 SHALL verify: stall=1 at pc=7 for 3 cycles, then take=1, target=16'h0100, stall=1 -> pc stays 7 during the stall cycles, then becomes 16'h0100 with flush=1.
REQ-036 SHALL verify: pc=16'hFFFF, no stall/take -> pc=16'h0000 with no flush.
REQ-037 SHALL verify: halt_req=1 and take=1 in the same cycle at pc=9 -> pc stays 9, halted=1, branch_cnt unchanged; start=1 -> pc=10 next increment.
REQ-038 SHALL verify: reset pulse in the flush cycle after a take -> flush=0 and pc=RESET_PC immediately; state IDLE.
